// File: rtl/udp_pkg.sv
// Shared definitions for the udp stimulus sequencer: state encoding, step count,
// default expected-z table and the 2-bit Gray helper.
package udp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      STEP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int NUM_STEPS = 4;

   // z expected from an ideal comparator, indexed by {x,y}: z = (x == y)
   localparam logic [3:0] EXP_TABLE_DEF = 4'b1001;

   function automatic logic [1:0] gray2(input logic [1:0] k);
      return k ^ (k >> 1);
   endfunction

endpackage

// File: rtl/udp_hold_timer.sv
// Loadable down-counter used for both the init window and each step hold window.
// expire_o is high in the last cycle of a window while the timer is enabled.
module udp_hold_timer #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [CW-1:0] val_i,
   input  logic          en_i,
   output logic          expire_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Load wins over counting; the counter parks at zero rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/udp_stim_seq.sv
// Stimulus sequencer for the udp comparator: init window at x=y=0, then Gray steps
// 00,01,11,10 each held HOLD_CYCLES, capturing z_in at the end of each step.
// Optional expected-value checking is enabled by defining UDP_STIM_CHECK_EN.
module udp_stim_seq
   import udp_pkg::*;
#(
   parameter int         INIT_CYCLES = 5,
   parameter int         HOLD_CYCLES = 20,
   parameter logic [3:0] EXP_TABLE   = EXP_TABLE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       z_in,
   output logic       x,
   output logic       y,
   output logic       busy,
   output logic       step_valid,
   output logic [1:0] step_idx,
   output logic [3:0] z_log,
   output logic       done,
   output logic       mismatch
);

   localparam int MAXW = (INIT_CYCLES > HOLD_CYCLES) ? INIT_CYCLES : HOLD_CYCLES;
   localparam int CW   = $clog2(MAXW + 1);
   localparam logic [CW-1:0] INIT_LD = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [1:0]    LAST_STEP = 2'(NUM_STEPS - 1);

   state_t        state_q, state_d;
   logic [1:0]    step_q, step_d;
   logic [1:0]    xy_q, xy_d;
   logic          sv_q, sv_d;
   logic          done_q, done_d;
   logic [3:0]    zlog_q, zlog_d;

   logic          tmr_load, tmr_en, tmr_exp;
   logic [CW-1:0] tmr_val;
   logic          accept, capture;

   udp_hold_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (tmr_load),
      .val_i    (tmr_val),
      .en_i     (tmr_en),
      .expire_o (tmr_exp)
   );

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      xy_d     = xy_q;
      sv_d     = 1'b0;
      done_d   = 1'b0;
      zlog_d   = zlog_q;
      tmr_load = 1'b0;
      tmr_val  = HOLD_LD;
      tmr_en   = 1'b0;
      accept   = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_d  = INIT;
               step_d   = 2'd0;
               zlog_d   = 4'd0;
               xy_d     = 2'b00;
               tmr_load = 1'b1;
               tmr_val  = INIT_LD;
            end
         end
         INIT: begin
            tmr_en = 1'b1;
            if (tmr_exp) begin
               state_d  = STEP;
               xy_d     = gray2(2'd0);
               tmr_load = 1'b1;
            end
         end
         STEP: begin
            tmr_en = 1'b1;
            if (tmr_exp) begin
               capture        = 1'b1;
               zlog_d[step_q] = z_in;
               sv_d           = 1'b1;
               // Last step: park the pattern at 00 and keep step_idx on the final step.
               if (step_q == LAST_STEP) begin
                  state_d = DONE;
                  xy_d    = 2'b00;
                  done_d  = 1'b1;
               end else begin
                  step_d   = step_q + 2'd1;
                  xy_d     = gray2(step_q + 2'd1);
                  tmr_load = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         xy_q    <= 2'b00;
         sv_q    <= 1'b0;
         done_q  <= 1'b0;
         zlog_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         xy_q    <= xy_d;
         sv_q    <= sv_d;
         done_q  <= done_d;
         zlog_q  <= zlog_d;
      end
   end

`ifdef UDP_STIM_CHECK_EN
   logic mis_q;

   // xy_q still holds the pattern of the step being captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= 1'b0;
      end else if (capture && (z_in != EXP_TABLE[xy_q])) begin
         mis_q <= 1'b1;
      end
   end

   assign mismatch = mis_q;
`else
   logic unused_chk;
   assign unused_chk = ^{EXP_TABLE, accept, capture};
   assign mismatch   = 1'b0;
`endif

   assign x          = xy_q[1];
   assign y          = xy_q[0];
   assign busy       = (state_q != IDLE);
   assign step_valid = sv_q;
   assign step_idx   = step_q;
   assign z_log      = zlog_q;
   assign done       = done_q;

endmodule
